// File: rtl/pmod_trace_streamer.sv
// rtl/pmod_trace_streamer.sv - fetch-trace FIFO serialised into LANE_W-wide framed beats
//
// Captures {PC, instruction, mode} fetch-trace entries into a DEPTH-entry FIFO and
// streams each entry out as a frame of LANE_W-wide beats with a valid/ready handshake.
// A frame is the address beats, MS lane first, followed by the data beats when mode=1.
//
// Ports:
//   sysclk       in   system clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   capture enable (gates pushes only)
//   trace_valid  in   trace_addr/trace_data/trace_mode valid this cycle
//   trace_addr   in   fetched PC
//   trace_data   in   fetched instruction word
//   trace_mode   in   0 = address-only frame, 1 = address+data frame
//   out_ready    in   sink accepts the current beat
//   clr_ovf      in   synchronous clear of overflow and drop_count
//   out_lane     out  current beat
//   out_valid    out  out_lane holds a valid beat
//   out_sof      out  current beat is the first beat of a frame
//   fifo_count   out  entries queued, excluding the frame in flight
//   overflow     out  sticky flag: at least one trace was dropped
//   drop_count   out  dropped traces, saturating at 255
module pmod_trace_streamer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int LANE_W = 8
) (
    input  logic                     sysclk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     trace_valid,
    input  logic [ADDR_W-1:0]        trace_addr,
    input  logic [DATA_W-1:0]        trace_data,
    input  logic                     trace_mode,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic [LANE_W-1:0]        out_lane,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int NA = ADDR_W / LANE_W;
    localparam int ND = DATA_W / LANE_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = ADDR_W + DATA_W;
    localparam int EW = SW + 1;
    localparam int BW = $clog2((NA > ND) ? NA : ND) + 1;

    typedef enum logic [1:0] {IDLE, SEND_ADDR, SEND_DATA} state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic            mode_q, mode_d;
    logic            sof_q, sof_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;

    logic            full, empty, push, drop, pop, xfer, eof;

    // Fullness uses the registered count, so a same-cycle pop never makes room.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = trace_valid && enable && !full;
    assign drop  = trace_valid && enable && full;
    assign xfer  = (state_q != IDLE) && out_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        sof_d   = sof_q;
        pop     = 1'b0;
        eof     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) pop = 1'b1;
            end
            SEND_ADDR: begin
                if (xfer) begin
                    shreg_d = shreg_q << LANE_W;
                    sof_d   = 1'b0;
                    if (beat_q == BW'(NA - 1)) begin
                        beat_d = '0;
                        if (mode_q) state_d = SEND_DATA;
                        else        eof     = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            SEND_DATA: begin
                if (xfer) begin
                    shreg_d = shreg_q << LANE_W;
                    sof_d   = 1'b0;
                    if (beat_q == BW'(ND - 1)) eof    = 1'b1;
                    else                      beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Back-to-back frames: pop on the last transfer so no bubble appears.
        if (eof) begin
            if (!empty) pop     = 1'b1;
            else        state_d = IDLE;
        end
        if (pop) begin
            {shreg_d, mode_d} = mem_q[rd_ptr_q];
            beat_d  = '0;
            sof_d   = 1'b1;
            state_d = SEND_ADDR;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as clr_ovf is counted after the clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem_q[wr_ptr_q] <= {trace_addr, trace_data, trace_mode};
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shreg_q  <= '0;
            mode_q   <= 1'b0;
            sof_q    <= 1'b0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            shreg_q  <= shreg_d;
            mode_q   <= mode_d;
            sof_q    <= sof_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign out_lane   = shreg_q[SW-1 -: LANE_W];
    assign out_valid  = (state_q != IDLE);
    assign out_sof    = sof_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pmod_trace_streamer.sv
// tb/tb_pmod_trace_streamer.sv - self-checking bench for pmod_trace_streamer
module tb_pmod_trace_streamer;
    logic        sysclk = 1'b0;
    logic        reset_n, enable, trace_valid, trace_mode, out_ready, clr_ovf;
    logic [31:0] trace_addr, trace_data;
    logic [7:0]  out_lane;
    logic        out_valid, out_sof, overflow;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;

    pmod_trace_streamer #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .LANE_W(8)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .trace_valid(trace_valid),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_mode(trace_mode),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_lane(out_lane), .out_valid(out_valid),
        .out_sof(out_sof), .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
    );

    always #4 sysclk = ~sysclk;

    typedef struct packed {
        logic [7:0] lane;
        logic       sof;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        mode;
        int          exp_len;
        logic [7:0]  exp_last;
    } vec_t;

    beat_t       sb_q[$];
    vec_t        tv[10];
    int          n_vec = 0;
    int          n_err = 0;
    int          xfer_cnt = 0;
    int          frame_len = 0;
    logic [7:0]  last_lane = 8'h00;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;

    always @(posedge sysclk) cyc++;

    // Scoreboard side: every accepted beat is popped and compared.
    always @(negedge sysclk) begin
        beat_t e;
        if (reset_n && out_valid && out_ready) begin
            xfer_cnt++;
            if (xfer_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (out_sof) frame_len = 1;
            else         frame_len++;
            last_lane = out_lane;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected actual lane=%02h sof=%b required none", out_lane, out_sof);
            end else begin
                e = sb_q.pop_front();
                if (out_lane !== e.lane || out_sof !== e.sof) begin
                    n_err++;
                    $display("FAIL beat actual lane=%02h sof=%b required lane=%02h sof=%b",
                             out_lane, out_sof, e.lane, e.sof);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [7:0] lane, input logic sof);
        beat_t e;
        e.lane = lane;
        e.sof  = sof;
        sb_q.push_back(e);
    endtask

    task automatic exp_frame(input logic [31:0] addr, input logic [31:0] data, input logic mode);
        for (int i = 0; i < 4; i++) exp_beat(8'(addr >> (24 - 8 * i)), (i == 0));
        if (mode)
            for (int i = 0; i < 4; i++) exp_beat(8'(data >> (24 - 8 * i)), 1'b0);
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic mode);
        trace_addr  = addr;
        trace_data  = data;
        trace_mode  = mode;
        trace_valid = 1'b1;
        @(posedge sysclk); #1;
        trace_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while ((sb_q.size() != 0 || out_valid) && b < 500) begin
            @(posedge sysclk); #1;
            b++;
        end
        chk(name, (b < 500), 1);
    endtask

    initial begin
        tv[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 8, 8'hEF};
        tv[1] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 4, 8'h78};
        tv[2] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 8, 8'h13};
        tv[3] = '{32'h8000_0000, 32'hA5A5_5A5A, 1'b0, 4, 8'h00};
        tv[4] = '{32'h0000_00FF, 32'h0102_0304, 1'b1, 8, 8'h04};
        tv[5] = '{32'hCAFE_F00D, 32'h0000_0001, 1'b0, 4, 8'h0D};
        tv[6] = '{32'h0000_0010, 32'h7FFF_FFFF, 1'b1, 8, 8'hFF};
        tv[7] = '{32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 4, 8'h0F};
        tv[8] = '{32'h0000_0020, 32'h00C0_FFEE, 1'b1, 8, 8'hEE};
        tv[9] = '{32'h0000_0024, 32'h0BAD_F00D, 1'b1, 8, 8'h0D};

        reset_n = 1'b0; enable = 1'b1; trace_valid = 1'b0; trace_mode = 1'b0;
        out_ready = 1'b1; clr_ovf = 1'b0; trace_addr = '0; trace_data = '0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_outputs", {out_lane, out_valid, out_sof, fifo_count, overflow, drop_count}, 0);
        reset_n = 1'b1;
        @(posedge sysclk); #1;

        // Address-only frame, literal beats, with first-beat latency.
        exp_beat(8'h00, 1'b1); exp_beat(8'h00, 1'b0); exp_beat(8'h00, 1'b0); exp_beat(8'h04, 1'b0);
        send(32'h0000_0004, 32'h00A0_0093, 1'b0);
        chk("t1_count_after_push", fifo_count, 1);
        chk("t1_valid_before_pop", out_valid, 0);
        @(posedge sysclk); #1;
        chk("t1_first_beat", {out_valid, out_sof, out_lane, fifo_count}, {1'b1, 1'b1, 8'h00, 4'd0});
        wait_drain("t1_drain");
        chk("t1_end", {out_valid, fifo_count}, 0);
        chk("t1_len", frame_len, 4);

        // Address+data frame, literal beats.
        exp_beat(8'h00, 1'b1); exp_beat(8'h00, 1'b0); exp_beat(8'h00, 1'b0); exp_beat(8'h04, 1'b0);
        exp_beat(8'h00, 1'b0); exp_beat(8'hA0, 1'b0); exp_beat(8'h00, 1'b0); exp_beat(8'h93, 1'b0);
        send(32'h0000_0004, 32'h00A0_0093, 1'b1);
        wait_drain("t2_drain");
        chk("t2_len", frame_len, 8);
        chk("t2_last", last_lane, 8'h93);

        // Backpressure for 5 cycles while beat 2 is presented.
        xfer_cnt = 0;
        exp_frame(32'h0000_0004, 32'h00A0_0093, 1'b1);
        send(32'h0000_0004, 32'h00A0_0093, 1'b1);
        begin
            int b = 0;
            while (xfer_cnt < 2 && b < 50) begin
                @(posedge sysclk); #1;
                b++;
            end
            chk("t3_wait", (b < 50), 1);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            chk("t3_hold", {out_valid, out_sof, out_lane}, {1'b1, 1'b0, 8'h00});
        end
        chk("t3_no_xfer", xfer_cnt, 2);
        @(posedge sysclk); #1;
        out_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_total", xfer_cnt, 8);

        // Table-driven single frames.
        for (int i = 0; i < 10; i++) begin
            exp_frame(tv[i].addr, tv[i].data, tv[i].mode);
            send(tv[i].addr, tv[i].data, tv[i].mode);
            wait_drain("tv_drain");
            chk("tv_len", frame_len, tv[i].exp_len);
            chk("tv_last", last_lane, tv[i].exp_last);
        end

        // Overflow: 10 pushes against a stalled sink, the 10th is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_frame(tv[i].addr, tv[i].data, tv[i].mode);
            send(tv[i].addr, tv[i].data, tv[i].mode);
        end
        chk("t4_count", fifo_count, 8);
        chk("t4_ovf", {overflow, drop_count}, {1'b1, 8'd1});
        chk("t4_head", {out_valid, out_sof, out_lane}, {1'b1, 1'b1, 8'h00});
        clr_ovf = 1'b1;
        @(posedge sysclk); #1;
        clr_ovf = 1'b0;
        chk("t4_clr", {overflow, drop_count}, 0);
        out_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_empty", fifo_count, 0);

        // Three back-to-back address-only frames with no bubble.
        xfer_cnt = 0;
        for (int i = 0; i < 3; i++) exp_frame(32'(4 * i), 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) send(32'(4 * i), 32'h0, 1'b0);
        wait_drain("t5_drain");
        chk("t5_beats", xfer_cnt, 12);
        chk("t5_no_gap", last_cyc - first_cyc, 11);
        chk("t5_last", last_lane, 8'h08);

        // Asynchronous reset mid-frame with 3 entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(tv[i].addr, tv[i].data, 1'b1);
        repeat (2) @(posedge sysclk);
        #1;
        chk("t6_pre", {out_valid, fifo_count}, {1'b1, 4'd3});
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async", {out_valid, fifo_count, overflow, out_sof}, 0);
        sb_q.delete();
        @(posedge sysclk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        exp_frame(tv[1].addr, tv[1].data, tv[1].mode);
        send(tv[1].addr, tv[1].data, tv[1].mode);
        wait_drain("t6_drain");
        chk("t6_len", frame_len, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pmod_trace_streamer.md
Name: pmod_trace_streamer

Overview:
- Captures fetch-trace pairs (PC address, instruction word) from the core into a parametrised FIFO.
- Streams each pair out as a frame of narrow beats over one PMOD-width lane, with a valid/ready handshake.
- Replaces the fixed 4-port, 32-bit address fan-out (one PMOD header per address byte).
- Sits between the instruction-fetch stage and the Zybo Z7 PMOD pins (or a logic-analyser capture bench).

Parameters:
- ADDR_W, 32, trace address width; must be a multiple of LANE_W.
- DATA_W, 32, trace data (instruction) width; must be a multiple of LANE_W.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- LANE_W, 8, output beat width (one PMOD header).

Ports:
- sysclk  in  1  system clock (125 MHz).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; gates pushes only.
- trace_valid  in  1  trace_addr/trace_data/trace_mode valid this cycle.
- trace_addr  in  ADDR_W  PC of fetched instruction.
- trace_data  in  DATA_W  fetched instruction word.
- trace_mode  in  1  0 = address-only frame, 1 = address+data frame; stored per entry.
- out_ready  in  1  sink accepts the current beat.
- clr_ovf  in  1  synchronous clear of overflow and drop_count.
- out_lane  out  LANE_W  current beat.
- out_valid  out  1  out_lane holds a valid beat.
- out_sof  out  1  current beat is the first beat of a frame.
- fifo_count  out  clog2(DEPTH)+1  entries queued, excluding the frame in flight.
- overflow  out  1  sticky: at least one trace dropped.
- drop_count  out  8  dropped traces, saturating at 255.

Behaviour:
- Reset, asynchronous and active-low:
  - All outputs 0.
  - FIFO empty, FSM in IDLE.
  - A frame in progress is abandoned; out_valid falls asynchronously.
- Push:
  - Occurs when trace_valid && enable && fifo not full; the entry stores {addr, data, mode}.
  - Fullness is evaluated before any same-cycle pop. When full, the push is dropped, overflow is set to 1, and drop_count increments (saturating at 255).
- Counters:
  - fifo_count registers the result: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Read/write pointers wrap modulo DEPTH.
- Beat definitions: NA = ADDR_W/LANE_W, ND = DATA_W/LANE_W.
  - A frame is the NA address beats, most significant lane first.
  - If the entry's mode = 1, the ND data beats follow, most significant lane first.
- Handshake:
  - A beat transfers on a rising edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_lane and out_sof hold stable.
  - out_valid never drops without a transfer, except on reset.
- FSM states and transitions:
  - IDLE: out_valid=0. If the FIFO is non-empty, pop the head into the shift register and the mode flag, clear the beat counter, and go to SEND_ADDR. out_valid=1 and out_sof=1 from the next cycle.
  - SEND_ADDR: on each transfer, shift by LANE_W and increment the beat counter; out_sof clears after the first transfer. On the NA-th transfer:
    - mode=1: go to SEND_DATA.
    - mode=0: apply the end-of-frame rule.
  - SEND_DATA: same shifting. The ND-th transfer applies the end-of-frame rule.
  - End of frame: if the FIFO is non-empty, pop in the same cycle and go to SEND_ADDR. out_valid stays 1 and out_sof=1 on the next beat, with no bubble. Otherwise go to IDLE.
- Latency: a push at edge t is visible in fifo_count after t; the IDLE pop happens at edge t+1; the first beat is valid in the cycle after edge t+1.
- enable low:
  - Blocks new pushes.
  - The frame in flight completes and queued entries drain.
- clr_ovf:
  - Clears overflow and drop_count.
  - A drop in the same cycle wins: overflow=1, drop_count=1.

Test Plan:
1. Reset, enable=1, out_ready=1; push addr=0x00000004, data=0x00A00093, mode=0 -> out_valid beats 00,00,00,04 on consecutive cycles, out_sof on beat 0 only, then out_valid=0, fifo_count=0.
2. Same push with mode=1 -> 8 beats: 00,00,00,04,00,A0,00,93; out_sof only on the first beat.
3. Mode=1 frame; drop out_ready for 5 cycles after beat 2 -> out_lane holds 00 (beat 2) and out_valid stays 1; resuming yields the remaining 04,00,A0,00,93 with none lost or duplicated.
4. out_ready=0; push 10 traces on consecutive cycles -> first trace enters the shift register, fifo_count=8, overflow=1, drop_count=1. Pulse clr_ovf -> overflow=0, drop_count=0. Raise out_ready -> 9 frames drain in push order.
5. out_ready=1; push addrs 0x0,0x4,0x8 with mode=0 on consecutive cycles -> 12 contiguous beats, out_sof at beats 0,4,8, no out_valid gap, last address lane 08.
6. Assert reset_n=0 mid-frame with 3 entries queued -> out_valid=0 immediately, fifo_count=0, overflow=0. After release, a new push produces a fresh frame starting with out_sof=1.
